// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the conv job sequencer and its stride helper.
package conv_seq_pkg;

  localparam int ADDRW_DEF = 12;
  localparam int DATAW_DEF = 16;
  localparam int N_MIN     = 4;
  localparam logic [15:0] SIZE_TERMINATOR = 16'h00FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_RD,
    S_HDR_CHK,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/conv_seq_stride_calc.sv
// Combinational size decode: maps a header N to the input/output address strides
// of that matrix and flags whether N is a legal engine dimension.
module conv_seq_stride_calc
  import conv_seq_pkg::*;
#(
  parameter int MAX_N = 64
) (
  input  logic [7:0]  n,
  output logic [16:0] in_stride,
  output logic [16:0] out_stride,
  output logic        legal
);

  logic [15:0] n_sq;
  logic [6:0]  p;
  logic [13:0] p_sq;

  // Input: header word plus N*N/2 packed pixels. Output: P*P pooled bytes, two per word.
  always_comb begin
    n_sq       = 16'(n) * 16'(n);
    p          = 7'((n - 8'd2) >> 1);
    p_sq       = 14'(p) * 14'(p);
    in_stride  = 17'(n_sq >> 1) + 17'd1;
    out_stride = 17'((15'(p_sq) + 15'd1) >> 1);
    legal      = !n[0] && (n >= 8'(N_MIN)) && (n <= 8'(MAX_N));
  end

endmodule

// File: rtl/conv_job_sequencer.sv
// Job controller for the conv+maxpool engine: walks the matrix list, launches the
// engine per matrix and arbitrates the input-SRAM read port. Optional watchdog: CONV_SEQ_TIMEOUT_EN.
module conv_job_sequencer
  import conv_seq_pkg::*;
#(
  parameter int ADDRW       = ADDRW_DEF,
  parameter int DATAW       = DATAW_DEF,
  parameter int MAX_N       = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dut_run,
  output logic             dut_busy,
  output logic [ADDRW-1:0] input_sram_read_address,
  input  logic [DATAW-1:0] input_sram_read_data,
  input  logic [ADDRW-1:0] eng_rd_addr,
  output logic             eng_start,
  output logic [ADDRW-1:0] eng_base_addr,
  output logic [7:0]       eng_n,
  output logic [ADDRW-1:0] eng_out_base,
  input  logic             eng_done,
  output logic             eng_abort,
  output logic [7:0]       mat_count,
  output logic             seq_err
);

  localparam int SUMW = ADDRW + 18;

  seq_state_t state, next_state;

  logic [ADDRW-1:0] cur_base, out_base;
  logic [16:0]      in_stride, out_stride, in_stride_q, out_stride_q;
  logic             hdr_legal, hdr_term, hdr_ok, timed_out;
  logic [SUMW-1:0]  cur_sum, out_sum;
  logic             sum_carry;

  conv_seq_stride_calc #(.MAX_N(MAX_N)) u_stride (
    .n          (input_sram_read_data[7:0]),
    .in_stride  (in_stride),
    .out_stride (out_stride),
    .legal      (hdr_legal)
  );

  assign hdr_term  = (input_sram_read_data == DATAW'(SIZE_TERMINATOR));
  assign hdr_ok    = hdr_legal && (input_sram_read_data[DATAW-1:8] == '0);
  assign cur_sum   = SUMW'(cur_base) + SUMW'(in_stride_q);
  assign out_sum   = SUMW'(out_base) + SUMW'(out_stride_q);
  assign sum_carry = (|cur_sum[SUMW-1:ADDRW]) || (|out_sum[SUMW-1:ADDRW]);
  assign dut_busy  = (state != S_IDLE);

`ifdef CONV_SEQ_TIMEOUT_EN
  logic [11:0] wd_cnt;

  // Cleared in LAUNCH so the first RUN cycle sees zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  wd_cnt <= '0;
    else if (state == S_LAUNCH) wd_cnt <= '0;
    else if (state == S_RUN)    wd_cnt <= wd_cnt + 12'd1;
  end

  assign timed_out = (state == S_RUN) && !eng_done && (wd_cnt == 12'(TIMEOUT_CYC - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // The engine owns the read port from LAUNCH onward so its first fetch is not delayed.
  always_comb begin
    next_state              = state;
    eng_start               = 1'b0;
    eng_abort               = 1'b0;
    input_sram_read_address = cur_base;
    case (state)
      S_IDLE:    if (dut_run) next_state = S_HDR_RD;
      S_HDR_RD:  next_state = S_HDR_CHK;
      S_HDR_CHK: next_state = (hdr_term || !hdr_ok) ? S_DONE : S_LAUNCH;
      S_LAUNCH: begin
        eng_start               = 1'b1;
        input_sram_read_address = eng_rd_addr;
        next_state              = S_RUN;
      end
      S_RUN: begin
        input_sram_read_address = eng_rd_addr;
        if (eng_done) begin
          next_state = S_NEXT;
        end else if (timed_out) begin
          eng_abort  = 1'b1;
          next_state = S_DONE;
        end
      end
      S_NEXT:    next_state = sum_carry ? S_DONE : S_HDR_RD;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Strides are captured with the header so NEXT is a plain add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_base      <= '0;
      out_base      <= '0;
      eng_base_addr <= '0;
      eng_out_base  <= '0;
      eng_n         <= '0;
      in_stride_q   <= '0;
      out_stride_q  <= '0;
      mat_count     <= '0;
      seq_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dut_run) begin
            cur_base  <= '0;
            out_base  <= '0;
            mat_count <= '0;
            seq_err   <= 1'b0;
          end
        end
        S_HDR_CHK: begin
          if (!hdr_term) begin
            if (!hdr_ok) begin
              seq_err <= 1'b1;
            end else begin
              eng_n         <= input_sram_read_data[7:0];
              eng_base_addr <= cur_base;
              eng_out_base  <= out_base;
              in_stride_q   <= in_stride;
              out_stride_q  <= out_stride;
            end
          end
        end
        S_RUN: begin
          if (timed_out) seq_err <= 1'b1;
        end
        S_NEXT: begin
          if (mat_count != 8'hFF) mat_count <= mat_count + 8'd1;
          if (sum_carry) begin
            seq_err <= 1'b1;
          end else begin
            cur_base <= cur_sum[ADDRW-1:0];
            out_base <= out_sum[ADDRW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_job_sequencer.sv
// Self-checking bench for conv_job_sequencer: SRAM and engine models, a list-walking
// reference model and a per-cycle compare process, plus directed literal checks.
module tb_conv_job_sequencer;

  logic        clk, reset, dut_run, dut_busy;
  logic [11:0] input_sram_read_address, eng_rd_addr, eng_base_addr, eng_out_base;
  logic [15:0] input_sram_read_data;
  logic        eng_start, eng_done, eng_abort, seq_err;
  logic [7:0]  eng_n, mat_count;

  conv_job_sequencer #(.ADDRW(12), .DATAW(16), .MAX_N(64), .TIMEOUT_CYC(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .dut_run                 (dut_run),
    .dut_busy                (dut_busy),
    .input_sram_read_address (input_sram_read_address),
    .input_sram_read_data    (input_sram_read_data),
    .eng_rd_addr             (eng_rd_addr),
    .eng_start               (eng_start),
    .eng_base_addr           (eng_base_addr),
    .eng_n                   (eng_n),
    .eng_out_base            (eng_out_base),
    .eng_done                (eng_done),
    .eng_abort               (eng_abort),
    .mat_count               (mat_count),
    .seq_err                 (seq_err)
  );

  typedef struct {int base; int n; int out_base;} launch_t;

  logic [15:0] mem [0:4095];
  launch_t     exp_q[$];
  launch_t     cmp_l;
  int          err_cnt = 0, chk_cnt = 0;
  int          eng_delay = 2, force_req = 0;
  bit          eng_hold = 0, timeout_test = 0;
  int          exp_ptr = 0, exp_out = 0, exp_count = 0, cur_n = 0, launches_seen = 0;
  bit          owned = 0, pending = 0, accept_pend = 0;
  int          mdl_launch, mdl_count;
  bit          mdl_err;
  int          cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    chk_cnt++;
    err_cnt++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Synchronous-read SRAM: data for the address seen at an edge appears just after it.
  initial begin
    logic [11:0] a;
    input_sram_read_data = '0;
    forever begin
      @(posedge clk);
      a = input_sram_read_address;
      #1 input_sram_read_data = mem[a];
    end
  end

  // Engine model: done arrives eng_delay+2 cycles into RUN unless held; reset kills it.
  initial begin
    bit st, active;
    int left, force_ack;
    eng_done = 1'b0; eng_rd_addr = 12'hA00; active = 0; left = 0; force_ack = 0;
    forever begin
      @(negedge clk);
      st = eng_start && !reset;
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (reset) begin
        active = 0;
      end else begin
        if (active) begin
          eng_rd_addr = eng_rd_addr + 12'd1;
          if (!eng_hold && left == 0) begin
            eng_done = 1'b1;
            active   = 0;
          end else if (left > 0) begin
            left--;
          end
        end
        if (st) begin
          active = 1;
          left   = eng_delay;
        end
      end
      if (force_req != force_ack) begin
        eng_done  = 1'b1;
        force_ack = force_req;
      end
    end
  end

  // Reference model: walk the header list from word 0 exactly as the job format defines it.
  task automatic buildModel(output int n_launch, output int count, output bit err);
    int p, o, n;
    logic [15:0] h;
    p = 0; o = 0; n_launch = 0; count = 0; err = 0;
    exp_q.delete();
    for (int k = 0; k < 1000; k++) begin
      h = mem[p];
      if (h == 16'h00FF) break;
      n = int'(h[7:0]);
      if (h[15:8] != 8'h00 || (n % 2) != 0 || n < 4 || n > 64) begin
        err = 1;
        break;
      end
      exp_q.push_back('{p, n, o});
      n_launch++;
      count = (count < 255) ? count + 1 : 255;
      p = p + 1 + n * n / 2;
      o = o + (((n - 2) / 2) * ((n - 2) / 2) + 1) / 2;
      if (p >= 4096 || o >= 4096) begin
        err = 1;
        break;
      end
    end
  endtask

  // Per-cycle compare: launch payloads, read-port owner and matrix count.
  initial begin
    int np, no;
    forever begin
      @(negedge clk);
      if (reset) begin
        owned = 0; pending = 0; accept_pend = 0;
        exp_ptr = 0; exp_out = 0; exp_count = 0;
        exp_q.delete();
      end else begin
        if (accept_pend) begin
          exp_ptr = 0; exp_out = 0; exp_count = 0; accept_pend = 0;
        end
        if (eng_start) begin
          launches_seen++;
          owned = 1;
          if (exp_q.size() == 0) begin
            chk_cnt++;
            err_cnt++;
            $display("[TB] FAIL unexpected_launch: base %0d n %0d", eng_base_addr, eng_n);
          end else begin
            cmp_l = exp_q.pop_front();
            checkOutput("launch_base", eng_base_addr, cmp_l.base);
            checkOutput("launch_n", eng_n, cmp_l.n);
            checkOutput("launch_out_base", eng_out_base, cmp_l.out_base);
            cur_n = cmp_l.n;
          end
        end
        if (owned) checkOutput("rd_addr_engine", input_sram_read_address, eng_rd_addr);
        else       checkOutput("rd_addr_header", input_sram_read_address, exp_ptr);
        checkOutput("mat_count", mat_count, exp_count);
        if (!timeout_test) checkOutput("eng_abort_idle", eng_abort, 0);
        if (pending) begin
          exp_count = (exp_count < 255) ? exp_count + 1 : 255;
          np = exp_ptr + 1 + cur_n * cur_n / 2;
          no = exp_out + (((cur_n - 2) / 2) * ((cur_n - 2) / 2) + 1) / 2;
          if (np < 4096 && no < 4096) begin
            exp_ptr = np;
            exp_out = no;
          end
          pending = 0;
        end
        if (owned && (eng_done || eng_abort)) begin
          owned   = 0;
          pending = eng_done;
        end
        if (dut_run && !dut_busy) accept_pend = 1;
      end
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 dut_run = 1'b1;
    @(posedge clk);
    #1 dut_run = 1'b0;
  endtask

  task automatic waitIdle(input bit poke, output int busy_cycles);
    bit poked, clr, ok;
    poked = 0; clr = 0; ok = 0; busy_cycles = 0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (clr) begin
        dut_run = 1'b0;
        clr = 0;
      end
      if (poke && eng_done && !poked) begin
        dut_run = 1'b1;
        poked = 1;
        clr = 1;
      end
      if (!dut_busy) begin
        ok = 1;
        break;
      end
      busy_cycles++;
    end
    dut_run = 1'b0;
    if (!ok) timeoutFail("wait_idle");
  endtask

  task automatic runJob(input bit poke, output int busy_cycles);
    buildModel(mdl_launch, mdl_count, mdl_err);
    launches_seen = 0;
    applyStimulus();
    waitIdle(poke, busy_cycles);
    checkOutput("job_launches", launches_seen, mdl_launch);
    checkOutput("job_mat_count", mat_count, mdl_count);
    checkOutput("job_seq_err", seq_err, mdl_err);
    checkOutput("job_leftover_launches", exp_q.size(), 0);
  endtask

  initial begin
    logic [15:0] bad_hdr [4];
    bad_hdr[0] = 16'h0007; bad_hdr[1] = 16'h0002; bad_hdr[2] = 16'h0042; bad_hdr[3] = 16'h0108;
    reset = 1'b1; dut_run = 1'b0;
    clearMem();
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", dut_busy, 0);
    checkOutput("rst_eng_start", eng_start, 0);
    checkOutput("rst_eng_abort", eng_abort, 0);
    checkOutput("rst_seq_err", seq_err, 0);
    checkOutput("rst_mat_count", mat_count, 0);
    checkOutput("rst_rd_addr", input_sram_read_address, 0);
    checkOutput("rst_eng_n", eng_n, 0);
    checkOutput("rst_eng_base", eng_base_addr, 0);
    checkOutput("rst_eng_out_base", eng_out_base, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] terminator only");
    mem[0] = 16'h00FF;
    runJob(0, cyc);
    checkOutput("term_busy_cycles", cyc, 3);
    checkOutput("term_mat_count", mat_count, 0);

    $display("[TB] single N=8 matrix");
    clearMem();
    mem[0] = 16'h0008; mem[33] = 16'h00FF;
    runJob(0, cyc);
    checkOutput("one_eng_n", eng_n, 8);
    checkOutput("one_eng_base", eng_base_addr, 0);
    checkOutput("one_hdr2_addr", input_sram_read_address, 33);
    checkOutput("one_mat_count", mat_count, 1);

    $display("[TB] N=8 then N=16");
    eng_delay = 3;
    mem[33] = 16'h0010; mem[162] = 16'h00FF;
    runJob(0, cyc);
    checkOutput("two_eng_base", eng_base_addr, 33);
    checkOutput("two_eng_n", eng_n, 16);
    checkOutput("two_eng_out_base", eng_out_base, 5);
    checkOutput("two_hdr3_addr", input_sram_read_address, 162);
    checkOutput("two_mat_count", mat_count, 2);
    checkOutput("two_busy_cycles", cyc, 21);

    $display("[TB] dut_run on the eng_done cycle");
    runJob(1, cyc);
    checkOutput("poke_busy_cycles", cyc, 21);
    checkOutput("poke_mat_count", mat_count, 2);

    $display("[TB] illegal headers");
    for (int i = 0; i < 4; i++) begin
      clearMem();
      mem[0] = bad_hdr[i];
      runJob(0, cyc);
      checkOutput("bad_seq_err", seq_err, 1);
      checkOutput("bad_busy_cycles", cyc, 3);
    end
    mem[0] = 16'h00FF;
    runJob(0, cyc);
    checkOutput("err_cleared", seq_err, 0);

    $display("[TB] address carry with N=64");
    clearMem();
    mem[0] = 16'h0040; mem[2049] = 16'h0040;
    runJob(0, cyc);
    checkOutput("carry_seq_err", seq_err, 1);
    checkOutput("carry_mat_count", mat_count, 2);
    checkOutput("carry_eng_base", eng_base_addr, 2049);
    checkOutput("carry_eng_out_base", eng_out_base, 481);
    checkOutput("carry_rd_addr", input_sram_read_address, 2049);

    $display("[TB] 256 matrices, count saturation");
    clearMem();
    eng_delay = 0;
    for (int i = 0; i < 256; i++) mem[i * 9] = 16'h0004;
    mem[2304] = 16'h00FF;
    runJob(0, cyc);
    checkOutput("sat_mat_count", mat_count, 255);
    checkOutput("sat_seq_err", seq_err, 0);
    checkOutput("sat_eng_base", eng_base_addr, 2295);
    checkOutput("sat_eng_out_base", eng_out_base, 255);
    checkOutput("sat_rd_addr", input_sram_read_address, 2304);

    clearMem();
    mem[0] = 16'h0008; mem[33] = 16'h00FF;
    eng_delay = 2;
    buildModel(mdl_launch, mdl_count, mdl_err);
    launches_seen = 0;
    eng_hold = 1;
`ifdef CONV_SEQ_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    timeout_test = 1;
    applyStimulus();
    for (int i = 0; i < 20 && !eng_start; i++) @(negedge clk);
    if (!eng_start) timeoutFail("wd_wait_start");
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (eng_abort) break;
    end
    checkOutput("wd_abort_cycle", cyc, 16);
    waitIdle(0, cyc);
    checkOutput("wd_seq_err", seq_err, 1);
    checkOutput("wd_mat_count", mat_count, 0);
    checkOutput("wd_busy", dut_busy, 0);
    timeout_test = 0;
    eng_hold = 0;
    repeat (5) @(negedge clk);
`else
    $display("[TB] withheld eng_done waits indefinitely");
    applyStimulus();
    repeat (40) @(negedge clk);
    checkOutput("hold_busy", dut_busy, 1);
    eng_hold = 0;
    waitIdle(0, cyc);
    checkOutput("hold_mat_count", mat_count, 1);
    checkOutput("hold_seq_err", seq_err, 0);
    checkOutput("hold_launches", launches_seen, 1);
`endif

    $display("[TB] reset during second RUN");
    mem[33] = 16'h0010; mem[162] = 16'h00FF;
    eng_delay = 3;
    buildModel(mdl_launch, mdl_count, mdl_err);
    launches_seen = 0;
    applyStimulus();
    for (int i = 0; i < 200 && launches_seen < 2; i++) @(negedge clk);
    if (launches_seen < 2) timeoutFail("rst_wait_second_launch");
    @(posedge clk);
    #1;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checkOutput("midrst_busy", dut_busy, 0);
    checkOutput("midrst_eng_start", eng_start, 0);
    checkOutput("midrst_eng_abort", eng_abort, 0);
    checkOutput("midrst_mat_count", mat_count, 0);
    checkOutput("midrst_eng_n", eng_n, 0);
    checkOutput("midrst_eng_base", eng_base_addr, 0);
    checkOutput("midrst_rd_addr", input_sram_read_address, 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    force_req++;
    launches_seen = 0;
    repeat (6) @(negedge clk);
    checkOutput("postrst_busy", dut_busy, 0);
    checkOutput("postrst_mat_count", mat_count, 0);
    checkOutput("postrst_launches", launches_seen, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

endmodule
